// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and helpers for the inter-stage pipeline register.
// Optional feature macro: PIPE_STAGE_PERF_EN (stall/flush event counters).
package pipe_pkg;

    // ADDI x0,x0,0 -- the canonical RISC-V NOP, used as the bubble payload
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Per-edge action applied uniformly to every slot
    typedef enum logic [1:0] {
        ADVANCE,
        HOLD,
        FLUSH
    } stage_ctrl_e;

    // Bits needed to count 0..depth valid slots (depth is at most 4 here,
    // the loop bound just leaves headroom)
    function automatic int occ_width(input int depth);
        int w;
        w = 1;
        for (int i = 1; i <= 8; i++) begin
            if ((depth + 1) > (1 << i)) w = i + 1;
        end
        return w;
    endfunction

    // Flush wins over stall; stall wins over advance
    function automatic stage_ctrl_e decode_ctrl(input logic stall, input logic flush);
        if (flush)      return FLUSH;
        else if (stall) return HOLD;
        else            return ADVANCE;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle between the hazard unit, upstream stage and
// the pipeline register. clk/rst stay as plain ports on the module.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    parameter int OCC_W = occ_width(DEPTH)
);
    logic             stall_i;
    logic             flush_i;
    logic             valid_i;
    logic [WIDTH-1:0] data_i;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic [OCC_W-1:0] occ_o;

    // Upstream stage + hazard unit side
    modport master (
        output stall_i, flush_i, valid_i, data_i,
        input  valid_o, data_o, occ_o
    );

    // Pipeline register side
    modport slave (
        input  stall_i, flush_i, valid_i, data_i,
        output valid_o, data_o, occ_o
    );
endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One valid+payload slot. An invalid slot always holds BUBBLE so the
// consumer can use the payload without looking at valid.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  stage_ctrl_e      ctrl,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Slot register: reset/flush load a bubble, hold keeps, advance shifts
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid <= 1'b0;
            data  <= BUBBLE;
        end else begin
            case (ctrl)
                FLUSH: begin
                    valid <= 1'b0;
                    data  <= BUBBLE;
                end
                HOLD: begin
                    valid <= valid;
                    data  <= data;
                end
                default: begin
                    // Gate on valid so a non-valid input never leaks its payload
                    valid <= up_valid;
                    data  <= up_valid ? up_data : BUBBLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH slots in series with
// global stall/flush and bubble insertion.
// Optional feature macro: PIPE_STAGE_PERF_EN adds saturating stall/flush
// event counters (stall_cnt_o, flush_cnt_o).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter int          DEPTH      = 1,
    parameter logic [31:0] BUBBLE_VAL = NOP_INSTR
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    pipe_stage_reg_if.slave      stage
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]          stall_cnt_o,
    output logic [31:0]          flush_cnt_o
`endif
);

    localparam int               OCC_W    = occ_width(DEPTH);
    // Zero-extend or truncate the bubble constant to the payload width
    localparam logic [WIDTH-1:0] BUBBLE_W = WIDTH'(BUBBLE_VAL);

    stage_ctrl_e                  ctrl;
    logic [DEPTH:0]               chain_valid;
    logic [DEPTH:0][WIDTH-1:0]    chain_data;
    logic [OCC_W-1:0]             occ;

    assign ctrl           = decode_ctrl(stage.stall_i, stage.flush_i);
    assign chain_valid[0] = stage.valid_i;
    assign chain_data[0]  = stage.data_i;

    // Slot k loads from slot k-1; slot 0 loads from the upstream stage
    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        pipe_slot #(
            .WIDTH  (WIDTH),
            .BUBBLE (BUBBLE_W)
        ) u_slot (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .ctrl     (ctrl),
            .up_valid (chain_valid[k]),
            .up_data  (chain_data[k]),
            .valid    (chain_valid[k+1]),
            .data     (chain_data[k+1])
        );
    end

    // Occupancy is a popcount of the slot valid flops only, so it changes on
    // the same edge as the slots and has no path from the inputs; with
    // DEPTH=1 it collapses to the single valid flop.
    always_comb begin
        occ = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            occ = occ + OCC_W'(chain_valid[k]);
        end
    end

    assign stage.valid_o = chain_valid[DEPTH];
    assign stage.data_o  = chain_data[DEPTH];
    assign stage.occ_o   = occ;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Saturating event counters: stall counts only when not overridden by flush
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (ctrl == HOLD && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (ctrl == FLUSH && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: DEPTH=3 and DEPTH=2 instances sharing clock and reset.
module tb_pipe_stage_reg;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    localparam logic [31:0] NOP = 32'h0000_0013;

    pipe_stage_reg_if #(.WIDTH(32), .DEPTH(3)) bus3 ();
    pipe_stage_reg_if #(.WIDTH(32), .DEPTH(2)) bus2 ();

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] sc3, fc3, sc2, fc2;
`endif

    pipe_stage_reg #(.WIDTH(32), .DEPTH(3), .BUBBLE_VAL(32'h0000_0013)) dut3 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .stage  (bus3)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt_o (sc3),
        .flush_cnt_o (fc3)
`endif
    );

    pipe_stage_reg #(.WIDTH(32), .DEPTH(2), .BUBBLE_VAL(32'h0000_0013)) dut2 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .stage  (bus2)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt_o (sc2),
        .flush_cnt_o (fc2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (sample and drive point)
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic v, input logic [31:0] d, input logic [31:0] o);
        chk({tag, ".d3.valid"}, 32'(bus3.valid_o), 32'(v));
        chk({tag, ".d3.data"},  bus3.data_o, d);
        chk({tag, ".d3.occ"},   32'(bus3.occ_o), o);
    endtask

    task automatic chk2(input string tag, input logic v, input logic [31:0] d, input logic [31:0] o);
        chk({tag, ".d2.valid"}, 32'(bus2.valid_o), 32'(v));
        chk({tag, ".d2.data"},  bus2.data_o, d);
        chk({tag, ".d2.occ"},   32'(bus2.occ_o), o);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus3.stall_i = 1'b0; bus3.flush_i = 1'b0; bus3.valid_i = 1'b1; bus3.data_i = 32'hDEAD_BEEF;
        bus2.stall_i = 1'b0; bus2.flush_i = 1'b0; bus2.valid_i = 1'b1; bus2.data_i = 32'hDEAD_BEEF;

        // Reset held with valid input and running clock
        for (int i = 0; i < 3; i++) begin
            tick;
            chk3("reset", 1'b0, NOP, 0);
            chk2("reset", 1'b0, NOP, 0);
        end
`ifdef PIPE_STAGE_PERF_EN
        chk("reset.stall_cnt", sc2, 32'd0);
        chk("reset.flush_cnt", fc2, 32'd0);
`endif
        rst_n = 1'b1;
        bus3.data_i = 32'h1000;
        bus2.data_i = 32'hA;

        // E1
        tick;
        chk3("lat.e1", 1'b0, NOP, 1);
        chk2("fill.e1", 1'b0, NOP, 1);
        bus3.data_i = 32'h1004;
        bus2.data_i = 32'hB;
        // E2
        tick;
        chk3("lat.e2", 1'b0, NOP, 2);
        chk2("fill.e2", 1'b1, 32'hA, 2);
        bus3.data_i = 32'h1008;
        bus2.stall_i = 1'b1; bus2.data_i = 32'hC0;
        // E3: first payload emerges exactly 3 edges after it was taken
        tick;
        chk3("lat.e3", 1'b1, 32'h1000, 3);
        chk2("stall.e3", 1'b1, 32'hA, 2);
        bus3.valid_i = 1'b0; bus3.data_i = 32'h1234;
        bus2.data_i = 32'hC1; bus2.valid_i = 1'b0;
        // E4
        tick;
        chk3("lat.e4", 1'b1, 32'h1004, 2);
        chk2("stall.e4", 1'b1, 32'hA, 2);
        bus3.data_i = 32'h0;
        bus2.data_i = 32'hC2; bus2.valid_i = 1'b1;
        // E5
        tick;
        chk3("lat.e5", 1'b1, 32'h1008, 1);
        chk2("stall.e5", 1'b1, 32'hA, 2);
        bus2.data_i = 32'hC3;
        // E6: the valid_i=0 slot comes out as a bubble, not 0x1234
        tick;
        chk3("bubble.e6", 1'b0, NOP, 0);
        chk2("stall.e6", 1'b1, 32'hA, 2);
        bus2.stall_i = 1'b0; bus2.valid_i = 1'b1; bus2.data_i = 32'hC;
        bus3.valid_i = 1'b1; bus3.data_i = 32'h2000;
        // E7: stall released, second entry advances
        tick;
        chk2("release.e7", 1'b1, 32'hB, 2);
        chk3("refill.e7", 1'b0, NOP, 1);
        bus2.stall_i = 1'b1; bus2.flush_i = 1'b1;
        bus3.data_i = 32'h2004;
        // E8: flush beats stall
        tick;
        chk2("flush_stall.e8", 1'b0, NOP, 0);
        chk3("refill.e8", 1'b0, NOP, 2);
        bus2.stall_i = 1'b0; bus2.flush_i = 1'b0; bus2.valid_i = 1'b0;
        bus3.data_i = 32'h3000;

        // Async reset between edges clears outputs before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        chk3("async_rst", 1'b0, NOP, 0);
        chk2("async_rst", 1'b0, NOP, 0);
`ifdef PIPE_STAGE_PERF_EN
        chk("async_rst.stall_cnt", sc2, 32'd0);
        chk("async_rst.flush_cnt", fc2, 32'd0);
`endif
        tick;
        chk3("rst_held", 1'b0, NOP, 0);
        rst_n = 1'b1;

        // First edge after release is a normal advance
        tick;
        chk3("post_rst", 1'b0, NOP, 1);
        bus3.valid_i = 1'b0;

        // Counters: 5 stall edges then 2 flush edges on dut2
        bus2.stall_i = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        bus2.stall_i = 1'b0; bus2.flush_i = 1'b1;
        for (int i = 0; i < 2; i++) tick;
        bus2.flush_i = 1'b0;
        chk2("after_flush", 1'b0, NOP, 0);
`ifdef PIPE_STAGE_PERF_EN
        chk("perf.stall_cnt", sc2, 32'd5);
        chk("perf.flush_cnt", fc2, 32'd2);
        chk("perf.d3.stall_cnt", sc3, 32'd0);
`endif
        tick;
        chk3("drain", 1'b0, NOP, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
